// File: rtl/mod_m_down_timer.sv
// mod_m_down_timer: programmable down-counting timer with reload register,
// one-shot / periodic modes and a registered terminal-count pulse.
module mod_m_down_timer #(
  parameter int M = 10,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         periodic,
  input  logic         start,
  input  logic         stop,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [N:0]   MW   = (N+1)'(M);
  localparam logic [N-1:0] MAXV = N'(M - 1);

  logic [0:0]   state_q;
  logic [N-1:0] reload_q;
  logic [N-1:0] count_q;
  logic         tc_q;
  logic [N-1:0] lv_c;
  logic [N-1:0] eff;

  always_comb begin
    lv_c = load_value;
    if ({1'b0, load_value} >= MW)
      lv_c = MAXV;
  end

  // a load in the same cycle as start bypasses the reload register
  assign eff = load ? lv_c : reload_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      reload_q <= MAXV;
      count_q  <= MAXV;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load)
        reload_q <= lv_c;
      if (stop) begin
        state_q <= IDLE;
      end else if (start) begin
        count_q <= eff;
        state_q <= RUN;
      end else if (state_q == RUN && en) begin
        if (count_q != '0) begin
          count_q <= count_q - 1'b1;
        end else begin
          tc_q <= 1'b1;
          if (periodic)
            count_q <= reload_q;
          else
            state_q <= IDLE;
        end
      end
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_mod_m_down_timer.sv
// tb_mod_m_down_timer: directed checks of reset, one-shot, periodic,
// clamp/bypass, strobe priority and mid-run reset.
module tb_mod_m_down_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_value;
  logic       periodic;
  logic       start;
  logic       stop;
  logic [3:0] count;
  logic       tc;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  mod_m_down_timer #(.M(10), .N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_value (load_value),
    .periodic   (periodic),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .tc         (tc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] c,
                      input logic b, input logic t);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".tc"},    32'(tc),    32'(t));
  endtask

  task automatic rand_in();
    en         = 1'($urandom_range(0, 1));
    load       = 1'($urandom_range(0, 1));
    load_value = 4'($urandom_range(0, 15));
    periodic   = 1'($urandom_range(0, 1));
    start      = 1'($urandom_range(0, 1));
    stop       = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_in();
    en = 0; load = 0; load_value = 0;
    periodic = 0; start = 0; stop = 0;
  endtask

  initial begin
    reset = 1'b0;
    rand_in();
    #1;
    tick(); rand_in();
    tick(); rand_in();
    chk3("reset", 4'd9, 1'b0, 1'b0);

    reset = 1'b1;
    idle_in();
    repeat (5) tick();
    chk3("idle_hold", 4'd9, 1'b0, 1'b0);

    // one-shot from reload 3
    load = 1; load_value = 4'd3;
    tick();
    load = 0; start = 1; en = 1; periodic = 0;
    tick();
    chk3("os.start", 4'd3, 1'b1, 1'b0);
    start = 0;
    tick(); chk3("os.c2", 4'd2, 1'b1, 1'b0);
    tick(); chk3("os.c1", 4'd1, 1'b1, 1'b0);
    tick(); chk3("os.c0", 4'd0, 1'b1, 1'b0);
    tick(); chk3("os.tc", 4'd0, 1'b0, 1'b1);
    tick(); chk3("os.after", 4'd0, 1'b0, 1'b0);

    // periodic, reload 2, gapped enable
    load = 1; load_value = 4'd2; en = 0;
    tick();
    load = 0; start = 1; periodic = 1; en = 1;
    tick(); chk3("per.start", 4'd2, 1'b1, 1'b0);
    start = 0;
    en = 1; tick(); chk3("per.e1", 4'd1, 1'b1, 1'b0);
    en = 0; tick(); chk3("per.e0", 4'd1, 1'b1, 1'b0);
    en = 1; tick(); chk3("per.e1b", 4'd0, 1'b1, 1'b0);
    en = 1; tick(); chk3("per.tc1", 4'd2, 1'b1, 1'b1);
    en = 0; tick(); chk3("per.e0b", 4'd2, 1'b1, 1'b0);
    en = 1; tick(); chk3("per.e1c", 4'd1, 1'b1, 1'b0);
    tick(); chk3("per.e1d", 4'd0, 1'b1, 1'b0);
    tick(); chk3("per.tc2", 4'd2, 1'b1, 1'b1);

    // clamp plus bypass
    load = 1; load_value = 4'd15; start = 1;
    tick(); chk3("clamp", 4'd9, 1'b1, 1'b0);
    load = 0; start = 0;

    // stop beats start
    repeat (4) tick();
    chk3("pri.c5", 4'd5, 1'b1, 1'b0);
    start = 1; stop = 1;
    tick(); chk3("pri.stop", 4'd5, 1'b0, 1'b0);
    start = 0; stop = 0;
    tick(); chk3("pri.idle", 4'd5, 1'b0, 1'b0);

    // start beats the zero-count edge
    load = 1; load_value = 4'd1;
    tick();
    load = 0; start = 1; periodic = 1; en = 1;
    tick(); chk3("zs.start", 4'd1, 1'b1, 1'b0);
    start = 0;
    tick(); chk3("zs.c0", 4'd0, 1'b1, 1'b0);
    start = 1;
    tick(); chk3("zs.restart", 4'd1, 1'b1, 1'b0);
    start = 0;

    // reset mid-run at count 1
    reset = 1'b0;
    tick(); chk3("mr.reset", 4'd9, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); chk3("mr.after", 4'd9, 1'b0, 1'b0);
    start = 1;
    tick(); chk3("mr.reload", 4'd9, 1'b1, 1'b0);
    start = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
